// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity constants and sizing helper
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_tx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Never returns 0 so a counter sized from it always has at least one bit.
   function automatic int ceil_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with count, shared by the UART tx and rx paths
// Push while full and pop while empty are ignored; read data is the head entry.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop,
   output logic [WIDTH-1:0]          pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// rtl/uart_tx_fifo_cfg.sv - FIFO-fed UART transmitter, configurable width/stop bits
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_cfg
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           i_Clock,
   input  logic                           i_Rst_n,
   input  logic                           i_Tx_DV,
   input  logic [DATA_BITS-1:0]           i_Tx_Byte,
   output logic                           o_Tx_Ready,
   output logic                           o_Tx_Serial,
   output logic                           o_Tx_Active,
   output logic                           o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH):0]    o_Fifo_Count
);

   localparam int CW = ceil_log2(CLKS_PER_BIT);
   localparam int BW = ceil_log2(DATA_BITS);
   localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);
`ifdef UART_TX_PARITY_EN
   localparam logic          PAR_SEL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
`endif

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       (PARITY_ODD != int'(PAR_EVEN) && PARITY_ODD != int'(PAR_ODD))) begin : g_bad_cfg
      $error("uart_tx_fifo_cfg: unsupported parameter set");
   end

   uart_tx_state_t       state_q, state_d;
   logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 serial_q, serial_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 clk_last, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (i_Clock),
      .rst_n     (i_Rst_n),
      .push      (i_Tx_DV),
      .push_data (i_Tx_Byte),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_Fifo_Count)
   );

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      shift_d    = shift_q;
      fifo_pop   = 1'b0;
      clk_last   = (clk_cnt_q == CLK_LAST);
      if (state_q != ST_IDLE) clk_cnt_d = clk_last ? '0 : clk_cnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            clk_cnt_d = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_data;
               state_d  = ST_START;
            end
         end
         ST_START: if (clk_last) begin
            bit_idx_d = '0;
            state_d   = ST_DATA;
         end
         ST_DATA: if (clk_last) begin
            if (bit_idx_q == BIT_LAST) begin
               stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               state_d    = ST_PARITY;
`else
               state_d    = ST_STOP;
`endif
            end else begin
               bit_idx_d = bit_idx_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (clk_last) state_d = ST_STOP;
`endif
         ST_STOP: if (clk_last) begin
            if (stop_idx_q == STOP_LAST) begin
               stop_idx_d = 1'b0;
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_data;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               stop_idx_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line outputs are registered from the current state, so they trail it by one cycle.
      serial_d = 1'b1;
      active_d = 1'b0;
      case (state_q)
         ST_START:  begin serial_d = 1'b0;               active_d = 1'b1; end
         ST_DATA:   begin serial_d = shift_q[bit_idx_q]; active_d = 1'b1; end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin serial_d = (^shift_q) ^ PAR_SEL; active_d = 1'b1; end
`endif
         ST_STOP:   begin serial_d = 1'b1;               active_d = 1'b1; end
         default:   begin serial_d = 1'b1;               active_d = 1'b0; end
      endcase
      done_d = (state_q == ST_STOP) && clk_last && (stop_idx_q == STOP_LAST);
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= ST_IDLE;
         clk_cnt_q  <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         serial_q   <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
      end
   end

   assign o_Tx_Ready  = !fifo_full;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Done   = done_q;

endmodule
